// File: rtl/irom_loader.sv
// irom_loader: streams a program image into the instruction ROM and then
// releases the core for execution.
//
// Ports:
//   clk, rst                  - clock and asynchronous active-high reset
//   start, load_len           - load request and the word count to load
//   in_valid, in_data, in_ready - word stream handshake
//   IROM_write_en/addr/wdata  - IROM write port
//   IROM_read_en              - instruction fetch enable
//   setup, PC_is_stall        - hold the control unit and the PC during a load
//   PC_is_writing_first_addr  - one-cycle command to load first_addr into the PC
//   first_addr                - boot address, always BOOT_ADDR
//   done, err                 - execution-release pulse / rejected-start pulse
module irom_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              IROM_write_en,
    output logic [ADDR_W-1:0] IROM_addr,
    output logic [31:0]       IROM_wdata,
    output logic              IROM_read_en,
    output logic              setup,
    output logic              PC_is_stall,
    output logic              PC_is_writing_first_addr,
    output logic [31:0]       first_addr,
    output logic              done,
    output logic              err
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_FIRST,
        S_RUN
    } state_t;

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;

    logic len_ok_c;
    logic xfer_c;
    logic last_c;

    assign first_addr = BOOT_ADDR;

    // A start is accepted only for 1..DEPTH words.
    assign len_ok_c = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
    assign xfer_c   = (state == S_LOAD) && in_valid && in_ready;
    assign last_c   = (cnt == (len_q - LEN_W'(1)));

    // Loader state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= S_IDLE;
            len_q                    <= '0;
            cnt                      <= '0;
            in_ready                 <= 1'b0;
            IROM_write_en            <= 1'b0;
            IROM_addr                <= '0;
            IROM_wdata               <= '0;
            IROM_read_en             <= 1'b0;
            setup                    <= 1'b1;
            PC_is_stall              <= 1'b1;
            PC_is_writing_first_addr <= 1'b0;
            done                     <= 1'b0;
            err                      <= 1'b0;
        end else begin
            // Strobes default low; each is raised for exactly one cycle.
            IROM_write_en <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len_ok_c) begin
                            len_q    <= load_len;
                            cnt      <= '0;
                            in_ready <= 1'b1;
                            state    <= S_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    // The accepted word is written on the following cycle.
                    if (xfer_c) begin
                        IROM_write_en <= 1'b1;
                        IROM_addr     <= cnt[ADDR_W-1:0];
                        IROM_wdata    <= in_data;
                        cnt           <= cnt + LEN_W'(1);
                        if (last_c) begin
                            in_ready <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // Last write is on the IROM port this cycle.
                    PC_is_writing_first_addr <= 1'b1;
                    state                    <= S_FIRST;
                end

                S_FIRST: begin
                    PC_is_writing_first_addr <= 1'b0;
                    setup                    <= 1'b0;
                    PC_is_stall              <= 1'b0;
                    IROM_read_en             <= 1'b1;
                    done                     <= 1'b1;
                    state                    <= S_RUN;
                end

                S_RUN: begin
                    if (start) begin
                        if (len_ok_c) begin
                            // Fetch is shut off before any reload write lands.
                            len_q        <= load_len;
                            cnt          <= '0;
                            in_ready     <= 1'b1;
                            setup        <= 1'b1;
                            PC_is_stall  <= 1'b1;
                            IROM_read_en <= 1'b0;
                            state        <= S_LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irom_loader.sv
// tb_irom_loader: directed stimulus for irom_loader, checked every cycle
// against a word-count/phase model plus literal expectations per scenario.
module tb_irom_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1024;
    localparam logic [31:0] BOOT   = 32'h0000_1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_data = '0;
    logic              in_ready;
    logic              IROM_write_en;
    logic [ADDR_W-1:0] IROM_addr;
    logic [31:0]       IROM_wdata;
    logic              IROM_read_en;
    logic              setup;
    logic              PC_is_stall;
    logic              PC_is_writing_first_addr;
    logic [31:0]       first_addr;
    logic              done;
    logic              err;

    irom_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .IROM_write_en(IROM_write_en), .IROM_addr(IROM_addr),
        .IROM_wdata(IROM_wdata), .IROM_read_en(IROM_read_en),
        .setup(setup), .PC_is_stall(PC_is_stall),
        .PC_is_writing_first_addr(PC_is_writing_first_addr),
        .first_addr(first_addr), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: words still owed, cycles left before release, and run mode.
    int          m_rem   = 0;
    int          m_post  = 0;
    int          m_next  = 0;
    bit          m_run   = 0;
    bit          m_done  = 0;
    bit          m_err   = 0;
    bit          m_we    = 0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem = 0; m_post = 0; m_next = 0; m_run = 0;
            m_done = 0; m_err = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        end else begin
            bit can_start;
            bit len_ok;
            can_start = (m_rem == 0) && (m_post == 0);
            len_ok    = (int'(load_len) >= 1) && (int'(load_len) <= int'(DEPTH));
            m_we = 0; m_done = 0; m_err = 0;
            if (m_post == 1) begin
                m_post = 0; m_run = 1; m_done = 1;
            end else if (m_post == 2) begin
                m_post = 1;
            end
            if (m_rem > 0 && in_valid) begin
                m_we = 1; m_addr = 32'(m_next); m_wdata = in_data;
                m_next++; m_rem--;
                if (m_rem == 0) m_post = 2;
            end else if (can_start && start) begin
                if (len_ok) begin
                    m_rem = int'(load_len); m_next = 0; m_run = 0;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_rem > 0));
        chk("write_en", 32'(IROM_write_en), 32'(m_we));
        if (m_we) begin
            chk("irom_addr", 32'(IROM_addr), m_addr);
            chk("irom_wdata", IROM_wdata, m_wdata);
        end
        chk("read_en", 32'(IROM_read_en), 32'(m_run));
        chk("setup", 32'(setup), 32'(!m_run));
        chk("pc_stall", 32'(PC_is_stall), 32'(!m_run));
        chk("pc_first", 32'(PC_is_writing_first_addr), 32'(m_post == 1));
        chk("done", 32'(done), 32'(m_done));
        chk("err", 32'(err), 32'(m_err));
        chk("first_addr", first_addr, BOOT);
        chk("we_re_excl", 32'(IROM_write_en && IROM_read_en), 32'd0);
    end

    // Write/pulse log for the literal scenario checks.
    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];
    int          err_cnt  = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (IROM_write_en) begin
            addr_log.push_back(32'(IROM_addr));
            data_log.push_back(IROM_wdata);
        end
        if (err)  err_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        addr_log.delete();
        data_log.delete();
        err_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        load_len = (ADDR_W+1)'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < addr_log.size()) begin
            chk({name, "_addr"}, addr_log[idx], a);
            chk({name, "_data"}, data_log[idx], d);
        end else begin
            chk({name, "_missing"}, 32'(addr_log.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_setup"}, 32'(setup), 32'd1);
        chk({name, "_stall"}, 32'(PC_is_stall), 32'd1);
        chk({name, "_read"}, 32'(IROM_read_en), 32'd0);
        chk({name, "_we"}, 32'(IROM_write_en), 32'd0);
        chk({name, "_first"}, 32'(PC_is_writing_first_addr), 32'd0);
        chk({name, "_ready"}, 32'(in_ready), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_addr"}, 32'(IROM_addr), 32'd0);
        chk({name, "_wdata"}, IROM_wdata, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset_vals("rst0");
        chk("first_addr_lit", first_addr, 32'h0000_1000);
        rst = 1'b0;
        tick();

        // Three-word load with in_valid held high.
        clear_log();
        do_start(3);
        in_valid = 1'b1;
        in_data = 32'hAAAA_0001; tick();
        in_data = 32'hBBBB_0002; tick();
        in_data = 32'hCCCC_0003; tick();
        in_valid = 1'b0;
        wait_done(10);
        chk("l3_setup", 32'(setup), 32'd0);
        chk("l3_read", 32'(IROM_read_en), 32'd1);
        chk("l3_nwr", 32'(addr_log.size()), 32'd3);
        chk_log("l3_w0", 0, 32'd0, 32'hAAAA_0001);
        chk_log("l3_w1", 1, 32'd1, 32'hBBBB_0002);
        chk_log("l3_w2", 2, 32'd2, 32'hCCCC_0003);
        chk("l3_done_cnt", 32'(done_cnt), 32'd1);
        tick();
        chk("l3_done_pulse", 32'(done), 32'd0);

        // Four-word reload from RUN with gaps in in_valid.
        clear_log();
        do_start(4);
        for (int i = 0; i < 8; i++) begin
            in_valid = ((i % 2) == 0);
            in_data  = 32'h1000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_done(10);
        chk("l4_nwr", 32'(addr_log.size()), 32'd4);
        chk_log("l4_w0", 0, 32'd0, 32'h1000);
        chk_log("l4_w1", 1, 32'd1, 32'h1002);
        chk_log("l4_w2", 2, 32'd2, 32'h1004);
        chk_log("l4_w3", 3, 32'd3, 32'h1006);

        // Rejected lengths from IDLE.
        do_reset();
        clear_log();
        do_start(0);
        tick();
        do_start(DEPTH + 1);
        tick();
        chk("rej_err_cnt", 32'(err_cnt), 32'd2);
        chk("rej_nwr", 32'(addr_log.size()), 32'd0);
        chk("rej_setup", 32'(setup), 32'd1);
        chk("rej_ready", 32'(in_ready), 32'd0);

        // Reset after two of five words, then a fresh two-word load.
        do_start(5);
        in_valid = 1'b1;
        in_data = 32'h5000_0000; tick();
        in_data = 32'h5000_0001; tick();
        chk("mid_we_before", 32'(IROM_write_en), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        clear_log();
        do_start(2);
        in_valid = 1'b1;
        in_data = 32'h6000_0000; tick();
        in_data = 32'h6000_0001; tick();
        in_valid = 1'b0;
        wait_done(10);
        chk("rl_nwr", 32'(addr_log.size()), 32'd2);
        chk_log("rl_w0", 0, 32'd0, 32'h6000_0000);
        chk_log("rl_w1", 1, 32'd1, 32'h6000_0001);

        // Single-word reload from RUN.
        clear_log();
        do_start(1);
        chk("r1_setup", 32'(setup), 32'd1);
        chk("r1_read", 32'(IROM_read_en), 32'd0);
        in_valid = 1'b1;
        in_data = 32'h7777_7777; tick();
        in_valid = 1'b0;
        wait_done(10);
        chk("r1_nwr", 32'(addr_log.size()), 32'd1);
        chk_log("r1_w0", 0, 32'd0, 32'h7777_7777);
        chk("r1_read_after", 32'(IROM_read_en), 32'd1);

        // start pulses during LOAD are ignored.
        clear_log();
        do_start(3);
        in_valid = 1'b1;
        start = 1'b1; load_len = 11'd1; in_data = 32'h8000_0000; tick();
        start = 1'b1; load_len = 11'd0; in_data = 32'h8000_0001; tick();
        start = 1'b0;                   in_data = 32'h8000_0002; tick();
        in_valid = 1'b0;
        wait_done(10);
        chk("ign_nwr", 32'(addr_log.size()), 32'd3);
        chk_log("ign_w2", 2, 32'd2, 32'h8000_0002);
        chk("ign_err_cnt", 32'(err_cnt), 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
